// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester drives start and the operands; the divider returns results and status.
interface seq_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake and registered results.
module seq_divider #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [N:0]     p_r, p_s;
  logic [N-1:0]   q_r, q_s;
  logic [N-1:0]   d_r, d_s;
  logic [CW-1:0]  c_r, c_s;
  logic           dz_r, dz_s;
  logic [N-1:0]   quo_r, quo_s;
  logic [N-1:0]   rem_r, rem_s;
  logic           zero_r, zero_s;
  logic           busy_r, done_r;
  logic [N:0]     trial_s;
  logic           accept_s;

  // Next-state and datapath: capture on accepted start, one restoring step per RUN cycle.
  always_comb begin
    state_s  = state_r;
    p_s      = p_r;
    q_s      = q_r;
    d_s      = d_r;
    c_s      = c_r;
    dz_s     = dz_r;
    quo_s    = quo_r;
    rem_s    = rem_r;
    zero_s   = zero_r;
    trial_s  = {p_r[N-1:0], q_r[N-1]} - {1'b0, d_r};
    accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));

    if (accept_s) begin
      state_s = RUN;
      p_s     = {(N + 1){1'b0}};
      q_s     = bus.dividend;
      d_s     = bus.divisor;
      c_s     = CW'(N);
      dz_s    = (bus.divisor == {N{1'b0}});
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RUN: begin
          // A set top bit means the trial went negative: keep the shifted remainder.
          if (!trial_s[N]) begin
            p_s = trial_s;
            q_s = {q_r[N-2:0], 1'b1};
          end else begin
            p_s = {p_r[N-1:0], q_r[N-1]};
            q_s = {q_r[N-2:0], 1'b0};
          end
          c_s = c_r - CW'(1);
          if (c_r == CW'(1)) begin
            state_s = DONE;
            quo_s   = q_s;
            rem_s   = p_s[N-1:0];
            zero_s  = dz_r;
          end else begin
            state_s = RUN;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and output registers; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      p_r     <= {(N + 1){1'b0}};
      q_r     <= {N{1'b0}};
      d_r     <= {N{1'b0}};
      c_r     <= {CW{1'b0}};
      dz_r    <= 1'b0;
      quo_r   <= {N{1'b0}};
      rem_r   <= {N{1'b0}};
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      p_r     <= p_s;
      q_r     <= q_s;
      d_r     <= d_s;
      c_r     <= c_s;
      dz_r    <= dz_s;
      quo_r   <= quo_s;
      rem_r   <= rem_s;
      zero_r  <= zero_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = zero_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider, checked against a plain
// arithmetic reference of unsigned division with the divide-by-zero rule.
module tb_seq_divider;
  localparam int N    = 4;
  localparam int MAXV = (1 << N) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = MAXV;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; start is sampled by the next rising edge.
  task automatic launch(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = N'(a);
    bus.divisor  = N'(b);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Starts at the negedge just after the accepting edge; ends at the done negedge.
  task automatic wait_done(input string tag, input bit noise, input int a, input int b);
    int edges = 0;
    int busy_cycles = 0;
    int q, r;
    while (bus.done !== 1'b1 && edges < 40) begin
      if (noise && edges == 1) begin
        bus.start    = 1'b1;
        bus.dividend = N'($urandom_range(MAXV, 0));
        bus.divisor  = N'($urandom_range(MAXV, 0));
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    ref_div(a, b, q, r);
    chk({tag, ".latency"}, 32'(edges), 32'(N));
    chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(N));
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, ".quotient"}, 32'(bus.quotient), 32'(q));
    chk({tag, ".remainder"}, 32'(bus.remainder), 32'(r));
    chk({tag, ".div_zero"}, 32'(bus.div_zero), 32'(b == 0));
    if (b != 0) begin
      chk({tag, ".invariant"}, 32'(int'(bus.quotient) * b + int'(bus.remainder)), 32'(a));
      chk({tag, ".rem_lt_div"}, 32'(int'(bus.remainder) < b), 32'd1);
    end
  endtask

  // One cycle after done with no restart: done drops and results hold.
  task automatic check_hold(input string tag, input int a, input int b);
    int q, r;
    ref_div(a, b, q, r);
    @(negedge clk);
    chk({tag, ".done_width"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".hold_q"}, 32'(bus.quotient), 32'(q));
    chk({tag, ".hold_r"}, 32'(bus.remainder), 32'(r));
    chk({tag, ".hold_dz"}, 32'(bus.div_zero), 32'(b == 0));
  endtask

  task automatic single(input string tag, input bit noise, input int a, input int b);
    launch(a, b);
    wait_done(tag, noise, a, b);
    check_hold(tag, a, b);
  endtask

  initial begin
    int a, b, na, nb;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.quotient", 32'(bus.quotient), 32'd0);
    chk("reset.remainder", 32'(bus.remainder), 32'd0);
    chk("reset.div_zero", 32'(bus.div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single("t1_13_3", 1'b0, 13, 3);
    single("t2_15_1", 1'b0, 15, 1);
    single("t2_2_9", 1'b0, 2, 9);
    single("t2_0_5", 1'b0, 0, 5);
    single("t3_7_0", 1'b0, 7, 0);
    single("t3_6_2", 1'b0, 6, 2);

    // Start during RUN is ignored; start held in the DONE cycle restarts at once.
    launch(12, 4);
    wait_done("t4_12_4", 1'b1, 12, 4);
    launch(9, 2);
    wait_done("t4_9_2", 1'b0, 9, 2);
    check_hold("t4_9_2", 9, 2);

    // Reset on the second RUN cycle aborts the division and clears the results.
    launch(14, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5.busy", 32'(bus.busy), 32'd0);
    chk("t5.done", 32'(bus.done), 32'd0);
    chk("t5.quotient", 32'(bus.quotient), 32'd0);
    chk("t5.remainder", 32'(bus.remainder), 32'd0);
    chk("t5.div_zero", 32'(bus.div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.idle_done", 32'(bus.done), 32'd0);
    single("t5_14_3", 1'b0, 14, 3);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(MAXV, 0));
      b = int'($urandom_range(MAXV, 0));
      single("rand", 1'($urandom_range(1, 0)), a, b);
    end

    // Exhaustive back-to-back sweep of every operand pair.
    launch(0, 0);
    for (int i = 0; i < 256; i++) begin
      a = i / 16;
      b = i % 16;
      wait_done("sweep", 1'b0, a, b);
      if (i < 255) begin
        na = (i + 1) / 16;
        nb = (i + 1) % 16;
        launch(na, nb);
      end else begin
        check_hold("sweep_end", a, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring unsigned divider. It is the inverse-direction companion to the array multiplier datapath: it takes a product-domain value and a factor, and recovers the quotient and remainder. It resolves one quotient bit per clock, MSB first, and uses a start/busy/done handshake. It serves as the check path for multiplier results and as a standalone arithmetic unit.

Parameters:
N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request pulse; sampled only in IDLE or DONE
dividend  input  N  unsigned dividend; captured on the accepted start edge
divisor  input  N  unsigned divisor; captured on the accepted start edge
quotient  output  N  unsigned quotient; registered
remainder  output  N  unsigned remainder; registered
busy  output  1  high while the division is in progress
done  output  1  one-cycle pulse; results are valid
div_zero  output  1  the last accepted divisor was 0; valid with done, held with the results

Behaviour:
- Reset is synchronous and active-low. On any clk edge with rst_n=0: state=IDLE; quotient, remainder and the internal partial remainder/counter are 0; busy=0, done=0, div_zero=0. Reset takes priority over every other input, including mid-division. The next start after rst_n returns to 1 is processed normally.
- Internal state: partial remainder P (N+1 bits), quotient shift register Q (N bits), captured divisor D (N bits), bit counter C (width clog2(N+1)).
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 -> RUN, and capture P=0, Q=dividend, D=divisor, C=N, div_zero=(divisor==0). Otherwise stay in IDLE.
  - RUN: one iteration per edge:
    - T = {P[N-1:0], Q[N-1]} - {1'b0, D}, computed at N+1 bits.
    - If T is non-negative (T[N]=0): P=T and Q={Q[N-2:0],1}.
    - Else: P={P[N-1:0],Q[N-1]} and Q={Q[N-2:0],0}.
    - C decrements by 1. On the edge where C goes 1->0, the next state is DONE.
  - DONE: lasts exactly one cycle. If start=1, the new operands are captured exactly as in IDLE and the next state is RUN (back-to-back operation). Otherwise -> IDLE.
- Outputs:
  - busy=1 exactly while state=RUN.
  - done=1 exactly while state=DONE.
  - On the RUN->DONE transition edge, quotient is loaded from Q and remainder from P[N-1:0].
  - quotient, remainder and div_zero then hold until the next RUN->DONE transition or reset. They do not change during RUN.
- Latency: if start is accepted at edge E0, busy is high for cycles E0..E(N-1), and done is high for the cycle after edge EN. That is N cycles from acceptance to done.
- start asserted while in RUN is ignored. It is not queued, and operands change during RUN have no effect.
- Divide by zero: no special datapath and the same latency. The algorithm naturally yields quotient = all ones (2^N-1) and remainder = dividend; div_zero=1.
- dividend < divisor: quotient=0, remainder=dividend.
- Invariant for every divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
1. Reset, then start with dividend=13, divisor=3 -> busy high 4 cycles; done pulse 4 cycles after the accepted edge; quotient=4, remainder=1, div_zero=0.
2. Run 15/1, then 2/9, then 0/5 -> (15,0), (0,2), (0,0). Each done is exactly one cycle wide, and results hold until the next done.
3. 7/0 -> quotient=15, remainder=7, div_zero=1 at done. A following 6/2 -> quotient=3, remainder=0, div_zero=0.
4. Start 12/4; pulse start with 9/2 during RUN -> ignored, result is (3,0). Then hold start high in the DONE cycle with 9/2 -> immediate restart, next result (4,1), busy high 4 cycles.
5. Start 14/3; drive rst_n=0 on the 2nd RUN cycle -> next edge: IDLE, busy=0, done=0, quotient=0, remainder=0. After releasing reset, 14/3 -> (4,2).
6. Exhaustive sweep, N=4: all 256 dividend/divisor pairs, back-to-back -> check the invariant for divisor != 0 and the divide-by-zero rule for divisor=0.
